// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer.
//
// Contents:
//   - default widths for the program counter and the instruction word
//   - FSM state encodings. These values appear on state_out, so they are fixed.
//   - run/step mode type
//   - helper that tells whether a state belongs to an instruction in flight
package seq_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_t;

  // An instruction is in flight from the start of its fetch until its
  // post-commit check. halt_req is only latched during these states.
  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_FETCH) || (st == ST_EXEC) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and the
// instruction memory (slave).
//
// Signals:
//   imem_req   master -> slave  fetch request
//   imem_addr  master -> slave  fetch address
//   imem_ack   slave  -> master fetched data valid
//   imem_data  slave  -> master fetched instruction
//
// Handshake: the master raises imem_req together with imem_addr and keeps
// both stable until it samples imem_ack high at a rising clk edge. That edge
// is the transfer: imem_data is captured at the same edge and imem_req drops
// after it. imem_ack has no meaning while imem_req is low. It may already be
// high in the first request cycle. The master may also drop imem_req without
// a transfer, either on a fetch timeout or on reset.
interface program_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/rise_edge.sv
// One-bit rising-edge detector that produces a registered one-cycle pulse.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_level  level input (button)
//   o_pulse  one-cycle pulse, one clock after i_level is sampled rising
//
// The history flop resets to 0. An input that is already high when reset is
// released therefore counts as an edge on the first clock.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_d;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= i_level;
      r_pulse   <= i_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/program_sequencer.sv
// Run/step/halt controller for the 8-bit single-cycle core.
//
// The sequencer fetches each instruction over the imem bus and holds it in
// instr_out. It then raises commit for one cycle to advance the core. After
// that it checks the new core PC for stop conditions: step mode, a pending
// halt request, a breakpoint, or a branch to self.
//
// Ports:
//   clk, RST            clock, asynchronous active-low reset
//   run_btn, step_btn   level buttons; a rising edge starts run / single step
//   halt_req            stop after the current instruction completes
//   bp_en, bp_addr      breakpoint enable and address
//   pc_in               core program counter
//   imem                fetch bus (master side)
//   instr_out           instruction register feeding the core
//   commit              one-cycle core advance enable
//   state_out           FSM state: IDLE=0 FETCH=1 EXEC=2 CHECK=3 HALTED=4 FAULT=5
//   running             mode is RUN and an instruction is in flight
//   halted, fault       state decodes
//   instr_count         retired instructions, saturating
module program_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  halt_req,
  input  logic                  bp_en,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic [PC_W-1:0]       pc_in,
  program_sequencer_if.master   imem,
  output logic [INSTR_W-1:0]    instr_out,
  output logic                  commit,
  output logic [2:0]            state_out,
  output logic                  running,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_W-1:0]      instr_count
);

  // The wait counter reaches WAIT_LAST in the final FETCH cycle that is
  // allowed without ack. The state is FETCH for exactly MAX_WAIT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [2:0]         r_state;
  mode_t              r_mode;
  logic               r_halt;
  logic [7:0]         r_wait;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_imem_addr;
  logic               r_imem_req;
  logic [INSTR_W-1:0] r_instr;
  logic [CNT_W-1:0]   r_count;

  logic w_run_edge;
  logic w_step_edge;
  logic w_start;
  logic w_active;
  logic w_halt_now;
  logic w_bp_hit;
  logic w_self_loop;

  rise_edge u_run_edge (
    .clk     (clk),
    .rst_n   (RST),
    .i_level (run_btn),
    .o_pulse (w_run_edge)
  );

  rise_edge u_step_edge (
    .clk     (clk),
    .rst_n   (RST),
    .i_level (step_btn),
    .o_pulse (w_step_edge)
  );

  assign w_start     = w_run_edge | w_step_edge;
  assign w_active    = is_active(r_state);
  // A request that arrives in the CHECK cycle itself also stops the run.
  assign w_halt_now  = r_halt | halt_req;
  assign w_bp_hit    = bp_en && (pc_in == bp_addr);
  assign w_self_loop = (pc_in == r_fetch_pc);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_STEP;
      r_halt      <= 1'b0;
      r_wait      <= '0;
      r_fetch_pc  <= '0;
      r_imem_addr <= '0;
      r_imem_req  <= 1'b0;
      r_instr     <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        // HALTED resumes the same way IDLE starts. The breakpoint is only
        // evaluated in CHECK, so resuming at bp_addr executes that instruction.
        ST_IDLE, ST_HALTED: begin
          if (w_start) begin
            r_state     <= ST_FETCH;
            // Step has priority when both edges arrive in the same cycle.
            r_mode      <= w_step_edge ? MODE_STEP : MODE_RUN;
            r_halt      <= 1'b0;
            r_imem_req  <= 1'b1;
            r_imem_addr <= pc_in;
            r_fetch_pc  <= pc_in;
            r_wait      <= '0;
          end
        end

        ST_FETCH: begin
          if (imem.imem_ack) begin
            r_instr    <= imem.imem_data;
            r_imem_req <= 1'b0;
            r_state    <= ST_EXEC;
          end else if (r_wait == WAIT_LAST) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        ST_EXEC: begin
          if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + 1'b1;
          end
          r_state <= ST_CHECK;
        end

        // pc_in now reflects the instruction committed in EXEC.
        ST_CHECK: begin
          if (r_mode == MODE_STEP || w_halt_now) begin
            r_state <= ST_IDLE;
          end else if (w_bp_hit || w_self_loop) begin
            r_state <= ST_HALTED;
          end else begin
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
            r_imem_addr <= pc_in;
            r_fetch_pc  <= pc_in;
            r_wait      <= '0;
          end
        end

        ST_FAULT: begin
          r_imem_req <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase

      // Latch halt requests while an instruction is in flight. The latch is
      // cleared only when a new start leaves IDLE/HALTED, which are never
      // active states, so the two updates cannot collide.
      if (w_active && halt_req) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_imem_addr;

  assign instr_out   = r_instr;
  assign commit      = (r_state == ST_EXEC);
  assign state_out   = r_state;
  assign running     = (r_mode == MODE_RUN) && w_active;
  assign halted      = (r_state == ST_HALTED);
  assign fault       = (r_state == ST_FAULT);
  assign instr_count = r_count;

endmodule
